// File: rtl/vga_sync_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_sync_gen
// Purpose  : Vertical line counter and registered VGA timing decoder. An
//            upstream counter supplies the horizontal position (h_value) and
//            an end-of-line strobe (v_enable). This block keeps the current
//            line number and turns the (h, v) position into sync, blanking
//            and pixel-coordinate outputs with one clock of latency.
// Ports    : clk          pixel clock, rising edge
//            rst_n        asynchronous active-low reset
//            h_value      horizontal position 0..H_TOTAL-1 from upstream
//            v_enable     end-of-line strobe, advances the line counter
//            v_value      current line 0..V_TOTAL-1
//            hsync        horizontal sync, active-low, registered
//            vsync        vertical sync, active-low, registered
//            video_on     visible-area flag, registered
//            pixel_x      visible column (0 while blanking), registered
//            pixel_y      visible row (0 while blanking), registered
//            frame_start  one-clock pulse after the line counter wraps
// Revision : 1.0 - initial release
// ============================================================================
module vga_sync_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK,
  localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK,
  // Enough bits to hold 0..TOTAL-1 (10 bits for the 800x525 default).
  localparam int HW       = $clog2(H_TOTAL),
  localparam int VW       = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [HW-1:0] h_value,
  input  logic          v_enable,
  output logic [VW-1:0] v_value,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic [HW-1:0] pixel_x,
  output logic [VW-1:0] pixel_y,
  output logic          frame_start
);

  // Window boundaries folded to counter width at elaboration so every
  // runtime comparison is a plain unsigned HW/VW-bit compare.
  localparam logic [HW-1:0] H_VIS_END  = HW'(H_VISIBLE);
  localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_VISIBLE + H_FRONT);
  localparam logic [HW-1:0] H_SYNC_END = HW'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [VW-1:0] V_VIS_END  = VW'(V_VISIBLE);
  localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_VISIBLE + V_FRONT);
  localparam logic [VW-1:0] V_SYNC_END = VW'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);

  logic in_visible;
  logic in_hsync;
  logic in_vsync;

  // Decoded from the current inputs and the line count held before the edge.
  // h_value beyond H_TOTAL-1 falls outside every window, so it reads as
  // blanking with hsync inactive; likewise for an out-of-range line count.
  assign in_visible = (h_value < H_VIS_END) && (v_value < V_VIS_END);
  assign in_hsync   = (h_value >= H_SYNC_BEG) && (h_value < H_SYNC_END);
  assign in_vsync   = (v_value >= V_SYNC_BEG) && (v_value < V_SYNC_END);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_value     <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      video_on    <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      frame_start <= 1'b0;
    end else begin
      // Level-sensitive: each high cycle of v_enable advances one line.
      // Using >= also recovers an out-of-range count on the next strobe.
      if (v_enable) begin
        if (v_value >= V_LAST) begin
          v_value <= '0;
        end else begin
          v_value <= v_value + VW'(1);
        end
      end
      frame_start <= v_enable && (v_value == V_LAST);
      hsync       <= ~in_hsync;
      vsync       <= ~in_vsync;
      video_on    <= in_visible;
      pixel_x     <= in_visible ? h_value : '0;
      pixel_y     <= in_visible ? v_value : '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_sync_gen
// Purpose  : Self-checking bench for vga_sync_gen. A driver issues one
//            (h_value, v_enable) pair per clock and pushes the response a
//            VGA timing reference predicts; a monitor pops and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_sync_gen;

  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;
  localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [9:0] h_value = '0;
  logic       v_enable = 1'b0;
  logic [9:0] v_value;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       frame_start;

  vga_sync_gen dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .h_value     (h_value),
    .v_enable    (v_enable),
    .v_value     (v_value),
    .hsync       (hsync),
    .vsync       (vsync),
    .video_on    (video_on),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    int v;
    bit hs;
    bit vs;
    bit vid;
    int px;
    int py;
    bit fs;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   model_v = 0;

  // Counters gathered by the monitor while 'counting' is set.
  bit   counting = 1'b0;
  int   hs_low_cnt = 0;
  int   vid_cnt = 0;
  int   fs_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference timing: which window a position falls in, straight from the
  // VGA porch/sync/visible widths.
  function automatic exp_t predict(input int h, input int v, input bit ven);
    exp_t e;
    bit vis;
    vis   = (h < H_VISIBLE) && (v < V_VISIBLE);
    e.hs  = !((h >= H_VISIBLE + H_FRONT) && (h < H_VISIBLE + H_FRONT + H_SYNC));
    e.vs  = !((v >= V_VISIBLE + V_FRONT) && (v < V_VISIBLE + V_FRONT + V_SYNC));
    e.vid = vis;
    e.px  = vis ? h : 0;
    e.py  = vis ? v : 0;
    e.fs  = ven && (v == V_TOTAL - 1);
    e.v   = ven ? ((v >= V_TOTAL - 1) ? 0 : v + 1) : v;
    return e;
  endfunction

  // One clock of stimulus; inputs change on the falling edge.
  task automatic cycle(input int h, input bit ven);
    exp_t e;
    @(negedge clk);
    h_value  = h[9:0];
    v_enable = ven;
    e = predict(h, model_v, ven);
    sb.push_back(e);
    model_v = e.v;
  endtask

  // Step lines (strobe then a random mid-line pixel) until the model is at target.
  task automatic advance_to(input int target);
    for (int i = 0; i < 2 * V_TOTAL && model_v != target; i++) begin
      cycle(0, 1'b1);
      cycle($urandom_range(1, H_TOTAL - 1), 1'b0);
    end
    chk("advance_to", model_v, target);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_v_value"},  v_value, 0);
    chk({tag, "_hsync"},    hsync, 1);
    chk({tag, "_vsync"},    vsync, 1);
    chk({tag, "_video_on"}, video_on, 0);
    chk({tag, "_pixel_x"},  pixel_x, 0);
    chk({tag, "_pixel_y"},  pixel_y, 0);
    chk({tag, "_frame_st"}, frame_start, 0);
  endtask

  // Monitor: every clock the DUT presents a new registered response.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("v_value",     v_value,     e.v);
      chk("hsync",       hsync,       e.hs);
      chk("vsync",       vsync,       e.vs);
      chk("video_on",    video_on,    e.vid);
      chk("pixel_x",     pixel_x,     e.px);
      chk("pixel_y",     pixel_y,     e.py);
      chk("frame_start", frame_start, e.fs);
      if (counting) begin
        if (!hsync) hs_low_cnt++;
        if (video_on) vid_cnt++;
        if (frame_start) fs_cnt++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset takes effect with no clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("rst_async");
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;

    // Line 0: full horizontal sweep.
    counting = 1'b1;
    for (int h = 0; h < H_TOTAL; h++) cycle(h, 1'b0);
    @(posedge clk);
    #2;
    counting = 1'b0;
    chk("sweep_hsync_low_clocks", hs_low_cnt, H_SYNC);
    chk("sweep_video_on_clocks", vid_cnt, H_VISIBLE);

    // One full frame of strobes from line 0.
    fs_cnt = 0;
    counting = 1'b1;
    for (int i = 0; i < V_TOTAL; i++) begin
      cycle(0, 1'b1);
      cycle($urandom_range(1, H_TOTAL - 1), 1'b0);
    end
    @(posedge clk);
    #2;
    counting = 1'b0;
    chk("frame_start_pulses", fs_cnt, 1);
    chk("frame_wrapped_model", model_v, 0);

    // Random positions including out-of-range h, sporadic strobes.
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 1023), ($urandom_range(0, 4) == 0));
    end

    // Visible-area corner.
    advance_to(V_VISIBLE - 1);
    cycle(H_VISIBLE - 1, 1'b0);
    cycle(H_VISIBLE, 1'b0);

    // Out-of-range h held for 10 clocks.
    for (int i = 0; i < 10; i++) cycle(900, 1'b0);

    // Strobe held high three cycles.
    advance_to(10);
    for (int i = 0; i < 3; i++) cycle(0, 1'b1);
    cycle(5, 1'b0);
    chk("held_strobe_model", model_v, 13);

    // Asynchronous reset mid-frame.
    advance_to(300);
    cycle(400, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_vals("rst_midframe");
    model_v = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("rst_midframe_frame_start", frame_start, 0);
      chk("rst_midframe_v_value", v_value, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cycle(0, 1'b1);
    cycle(7, 1'b0);
    for (int i = 0; i < 200; i++) begin
      cycle($urandom_range(0, H_TOTAL - 1), ($urandom_range(0, 3) == 0));
    end

    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
